// File: rtl/wb_arbiter_if.sv
// Register-file write port bundle shared by write-back,
// the MDU result path and the write arbiter.
interface wb_arbiter_if;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd_num;
  logic [31:0] i_wb_rd;
  logic        i_mdu_valid;
  logic [4:0]  i_mdu_rd_num;
  logic [31:0] i_mdu_rd;
  logic        o_mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd_num;
  logic [31:0] rf_rd;
  logic        stall_req;
  logic        o_err;

  modport slave (
    input  i_wb_valid, i_wb_rd_num, i_wb_rd,
    input  i_mdu_valid, i_mdu_rd_num, i_mdu_rd,
    output o_mdu_ready, rf_we, rf_rd_num, rf_rd,
    output stall_req, o_err
  );

  modport master (
    output i_wb_valid, i_wb_rd_num, i_wb_rd,
    output i_mdu_valid, i_mdu_rd_num, i_mdu_rd,
    input  o_mdu_ready, rf_we, rf_rd_num, rf_rd,
    input  stall_req, o_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between
// write-back and a buffered MDU result with starvation stall.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  wb_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic [4:0]  hold_num;
  logic [31:0] hold_dat;
  logic        cap;
  logic        wb_req;
  logic        we_nxt;
  logic [4:0]  num_nxt;
  logic [31:0] dat_nxt;
  logic        err_nxt;

  assign wb_req  = bus.i_wb_valid &&
                   (bus.i_wb_rd_num != 5'd0);
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  assign bus.o_mdu_ready = (state == IDLE) && !i_rst;
  assign bus.stall_req   = (state == STALL);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    we_nxt    = 1'b0;
    num_nxt   = bus.rf_rd_num;
    dat_nxt   = bus.rf_rd;
    err_nxt   = bus.o_err;
    unique case (state)
      IDLE: begin
        if (wb_req) begin
          we_nxt  = 1'b1;
          num_nxt = bus.i_wb_rd_num;
          dat_nxt = bus.i_wb_rd;
        end
        if (bus.i_mdu_valid) begin
          cap       = 1'b1;
          state_nxt = PEND;
          cnt_nxt   = 4'd0;
        end
      end
      PEND: begin
        if (wb_req) begin
          we_nxt  = 1'b1;
          num_nxt = bus.i_wb_rd_num;
          dat_nxt = bus.i_wb_rd;
          // Same target: the younger write-back value wins
          if (bus.i_wb_rd_num == hold_num) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= LIM) state_nxt = STALL;
          end
        end else begin
          if (hold_num != 5'd0) begin
            we_nxt  = 1'b1;
            num_nxt = hold_num;
            dat_nxt = hold_dat;
          end
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      STALL: begin
        if (hold_num != 5'd0) begin
          we_nxt  = 1'b1;
          num_nxt = hold_num;
          dat_nxt = hold_dat;
        end
        if (wb_req) err_nxt = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      hold_num      <= 5'd0;
      hold_dat      <= 32'd0;
      bus.rf_we     <= 1'b0;
      bus.rf_rd_num <= 5'd0;
      bus.rf_rd     <= 32'd0;
      bus.o_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.rf_we     <= we_nxt;
      bus.rf_rd_num <= num_nxt;
      bus.rf_rd     <= dat_nxt;
      bus.o_err     <= err_nxt;
      if (cap) begin
        hold_num <= bus.i_mdu_rd_num;
        hold_dat <= bus.i_mdu_rd;
      end
    end
  end
endmodule
